// File: rtl/conv_sequencer.sv
// conv_sequencer: frame-level controller for the 2x2 convolution neuron.
// Slides a 2x2 window (stride 1, valid padding) over an IMG_W x IMG_H image.
// For each window it fetches four pixels, hands them to the neuron with the
// latched kernel, captures the registered neuron result and streams it out
// over a valid/ready interface.
module conv_sequencer #(
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int ADDR_W  = 6,
    parameter int OADDR_W = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [31:0]        cfg_kernel,
    output logic               busy,
    output logic               done,
    output logic               mem_rd_en,
    output logic [ADDR_W-1:0]  mem_rd_addr,
    input  logic [7:0]         mem_rd_data,
    output logic [31:0]        neu_kernel,
    output logic [31:0]        neu_pixels,
    input  logic [7:0]         neu_result,
    output logic               res_valid,
    input  logic               res_ready,
    output logic [7:0]         res_data,
    output logic [OADDR_W-1:0] res_addr,
    output logic               res_last
);

    localparam int COL_W = (IMG_W > 2) ? $clog2(IMG_W) : 1;
    localparam int ROW_W = (IMG_H > 2) ? $clog2(IMG_H) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 2);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DRAIN = 3'd2,
        ISSUE = 3'd3,
        CAPT  = 3'd4,
        OUT   = 3'd5,
        FIN   = 3'd6
    } state_t;

    state_t state, state_next;

    logic [1:0]         idx;       // fetch step within the current window
    logic [1:0]         idx_m1;    // lane receiving the data returned this cycle
    logic [COL_W-1:0]   ocol;
    logic [ROW_W-1:0]   orow;
    // Top-left pixel address of the window, tracked incrementally so the
    // row*IMG_W product is never formed in hardware.
    logic [ADDR_W-1:0]  base;
    logic [OADDR_W-1:0] oidx;      // running result index
    logic               last_win;

    assign idx_m1   = idx - 2'd1;
    assign last_win = (orow == ROW_LAST) && (ocol == COL_LAST);

    // State register; reset abandons any frame in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state decode plus the combinational memory strobe and status flags.
    always_comb begin
        state_next  = state;
        mem_rd_en   = 1'b0;
        mem_rd_addr = '0;
        busy        = (state != IDLE);
        done        = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = FETCH;
            end
            FETCH: begin
                mem_rd_en = 1'b1;
                case (idx)
                    2'd0:    mem_rd_addr = base;
                    2'd1:    mem_rd_addr = base + ADDR_W'(1);
                    2'd2:    mem_rd_addr = base + ADDR_W'(IMG_W);
                    default: mem_rd_addr = base + ADDR_W'(IMG_W) + ADDR_W'(1);
                endcase
                if (idx == 2'd3) state_next = DRAIN;
            end
            DRAIN: state_next = ISSUE;
            ISSUE: state_next = CAPT;
            CAPT:  state_next = OUT;
            OUT: begin
                if (res_ready) state_next = res_last ? FIN : FETCH;
            end
            FIN: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: kernel latch, pixel lanes, window counters and result register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            ocol       <= '0;
            orow       <= '0;
            base       <= '0;
            oidx       <= '0;
            neu_kernel <= '0;
            neu_pixels <= '0;
            res_valid  <= 1'b0;
            res_data   <= '0;
            res_addr   <= '0;
            res_last   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        neu_kernel <= cfg_kernel;
                        idx        <= '0;
                        ocol       <= '0;
                        orow       <= '0;
                        base       <= '0;
                        oidx       <= '0;
                    end
                end
                FETCH: begin
                    idx <= idx + 2'd1;
                    // Read data lags the strobe by one cycle, so step 0 has nothing to store.
                    if (idx != 2'd0) neu_pixels[{idx_m1, 3'b000} +: 8] <= mem_rd_data;
                end
                DRAIN: begin
                    neu_pixels[31:24] <= mem_rd_data;
                end
                CAPT: begin
                    res_data  <= neu_result;
                    res_addr  <= oidx;
                    res_last  <= last_win;
                    res_valid <= 1'b1;
                end
                OUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        res_last  <= 1'b0;
                        if (!res_last) begin
                            oidx <= oidx + OADDR_W'(1);
                            if (ocol == COL_LAST) begin
                                ocol <= '0;
                                orow <= orow + ROW_W'(1);
                                // Skipping the last column lands on the next row start.
                                base <= base + ADDR_W'(2);
                            end else begin
                                ocol <= ocol + COL_W'(1);
                                base <= base + ADDR_W'(1);
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/conv_sequencer.md
Name: conv_sequencer

Overview:
Frame-level controller for the 2x2 convolution neuron. It walks a 2x2 window (stride 1, valid padding) over an IMG_W x IMG_H 8-bit image held in a single-read-port pixel memory. For each window it fetches four pixels, presents them with a latched kernel to the neuron, captures the registered neuron result, and streams it out over a valid/ready interface. It sits between the frame memory, one neuron instance and the result sink.

Parameters:
IMG_W, 8, image width in pixels (>=2)
IMG_H, 8, image height in pixels (>=2)
ADDR_W, 6, pixel memory address width (2**ADDR_W >= IMG_W*IMG_H)
OADDR_W, 6, result index width (2**OADDR_W >= (IMG_W-1)*(IMG_H-1))

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
start  in  1  one-cycle frame start request; sampled only in IDLE
cfg_kernel  in  32  kernel weights; lane i = bits [8i+7:8i]; latched on accepted start
busy  out  1  high from cycle after accepted start until done pulse (inclusive)
done  out  1  one-cycle pulse after last result handshake
mem_rd_en  out  1  pixel memory read strobe
mem_rd_addr  out  ADDR_W  pixel address = row*IMG_W + col
mem_rd_data  in  8  read data, valid exactly 1 cycle after mem_rd_en
neu_kernel  out  32  kernel to neuron, held constant for whole frame
neu_pixels  out  32  packed pixels to neuron, lane i = bits [8i+7:8i]
neu_result  in  8  neuron registered result (1-cycle latency from neu_pixels)
res_valid  out  1  result valid
res_ready  in  1  sink ready
res_data  out  8  convolution result
res_addr  out  OADDR_W  result index = orow*(IMG_W-1) + ocol
res_last  out  1  high with final result of frame

Behaviour:
- Reset (async, rst=1): state IDLE; busy, done, mem_rd_en, res_valid, res_last = 0; mem_rd_addr, res_data, res_addr, neu_pixels, neu_kernel = 0; orow/ocol counters = 0. Reset mid-frame abandons the frame; no done.
- States: IDLE, FETCH, DRAIN, ISSUE, CAPT, OUT, FIN.
- IDLE: start=1 -> latch cfg_kernel into neu_kernel, orow=ocol=0, busy=1, go FETCH. start in any other state is ignored.
- FETCH: 4 cycles, idx 0..3; mem_rd_en=1, addr for idx 0..3 = (orow,ocol), (orow,ocol+1), (orow+1,ocol), (orow+1,ocol+1). Data returning each cycle is written into neu_pixels lane idx-1. After idx 3 -> DRAIN.
- DRAIN: mem_rd_en=0; capture lane 3; -> ISSUE.
- ISSUE: neu_pixels stable with all 4 lanes; neuron registers at end of cycle; -> CAPT.
- CAPT: res_data <= neu_result, res_addr <= index, res_last <= (orow==IMG_H-2 && ocol==IMG_W-2); res_valid <= 1; -> OUT.
- OUT: hold res_valid/res_data/res_addr/res_last stable until res_valid && res_ready. On handshake: res_valid <= 0; if last -> FIN, else advance ocol (wrap to 0 at IMG_W-1, then orow++) and -> FETCH.
- FIN: done=1 for one cycle, busy=0 next cycle, -> IDLE. busy is high during FIN.
- Throughput: 8 cycles per result with res_ready tied high; first mem_rd_en is in the cycle after start is accepted; frame = 8*(IMG_W-1)*(IMG_H-1) + 1 (FIN) cycles.
- Arithmetic: the controller does not modify the result; neuron 8-bit wrap (mod 256) is passed through unchanged.
- neu_pixels lanes hold old values during FETCH; they are relevant to the neuron only in ISSUE.
- No window crosses a row: ocol max = IMG_W-2, orow max = IMG_H-2.

Test Plan:
- Image pix[a]=a (8x8), kernel 0x00000001, res_ready=1 -> 49 results, result k (orow=r, ocol=c) = 8r+c, res_addr = 7r+c, res_last only at k=48, done 1 cycle after its handshake.
- All pixels 1, kernel 0x01010101 -> every res_data=4. Cycle count start->done = 393.
- All pixels 0x80, kernel 0x02020202 -> res_data=0x00 (wrap mod 256); verify no saturation.
- Random res_ready backpressure (50%) -> res_data/res_addr stable while res_valid && !res_ready; sequence of results identical to the no-backpressure run; no mem reads during OUT.
- start re-pulsed mid-frame with a different cfg_kernel -> ignored; neu_kernel unchanged and results match the first kernel.
- rst asserted during OUT of result 10 -> outputs zero immediately; new start yields full 49-result frame from index 0.
